// File: rtl/rf_onehot_8x16_pkg.sv
// Shared constants and helpers for the one-hot addressed register file.
//   RF_WIDTH  : default register data width
//   RF_NREG   : number of registers (= write select width)
//   RF_ADDR_W : read address width
//   is_onehot8: 1 when exactly one bit of an 8-bit vector is set
package rf_onehot_8x16_pkg;

    localparam int unsigned RF_WIDTH  = 16;
    localparam int unsigned RF_NREG   = 8;
    localparam int unsigned RF_ADDR_W = 3;

    // Non-zero and clearing the lowest set bit leaves nothing behind.
    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/rf_reg.sv
// Single WIDTH-bit storage register with synchronous active-low reset and load enable.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : load d on the rising edge
//   d / q      : data in / registered data out
module rf_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rf_onehot_8x16.sv
// Eight-entry register file, write port addressed by a one-hot select from the
// write decoder, two combinational read ports with optional write forwarding.
//   clk, rst_n          : clock, synchronous active-low reset
//   wr_en/wr_sel/wr_data: write request, one-hot register select, write data
//   rd1_addr, rd2_addr  : read indices
//   rd1_data, rd2_data  : combinational read data (forwarded when BYPASS)
//   sel_err             : sticky, set by a write with a malformed select
//   wr_count            : committed writes since reset, wraps at 256
module rf_onehot_8x16
    import rf_onehot_8x16_pkg::*;
#(
    parameter int unsigned WIDTH  = RF_WIDTH,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [RF_NREG-1:0]   wr_sel,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [RF_ADDR_W-1:0] rd1_addr,
    input  logic [RF_ADDR_W-1:0] rd2_addr,
    output logic [WIDTH-1:0]     rd1_data,
    output logic [WIDTH-1:0]     rd2_data,
    output logic                 sel_err,
    output logic [7:0]           wr_count
);

    logic             sel_ok_c;
    logic             commit_c;
    logic [WIDTH-1:0] regs [RF_NREG];

    assign sel_ok_c = is_onehot8(wr_sel);
    assign commit_c = wr_en & sel_ok_c;

    // Storage: each register loads only when the write is well formed and selects it.
    for (genvar i = 0; i < RF_NREG; i++) begin : g_reg
        rf_reg #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (commit_c & wr_sel[i]),
            .d     (wr_data),
            .q     (regs[i])
        );
    end

    // Commit counter and sticky malformed-select flag; reset discards a coincident write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count <= 8'd0;
            sel_err  <= 1'b0;
        end else begin
            if (commit_c) begin
                wr_count <= wr_count + 8'd1;
            end
            if (wr_en && !sel_ok_c) begin
                sel_err <= 1'b1;
            end
        end
    end

    // Read muxes; a valid same-cycle write to the addressed register is forwarded.
    always_comb begin
        rd1_data = regs[rd1_addr];
        rd2_data = regs[rd2_addr];
        if (BYPASS) begin
            if (commit_c && wr_sel[rd1_addr]) begin
                rd1_data = wr_data;
            end
            if (commit_c && wr_sel[rd2_addr]) begin
                rd2_data = wr_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_onehot_8x16.sv
// Scoreboard bench: driver pushes expected read/flag/count values per cycle,
// a negedge monitor pops and compares against a forwarding and a non-forwarding instance.
module tb_rf_onehot_8x16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_sel;
    logic [15:0] wr_data;
    logic [2:0]  rd1_addr, rd2_addr;
    logic [15:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_err, n_err;
    logic [7:0]  b_cnt, n_cnt;

    always #5 clk = ~clk;

    rf_onehot_8x16 #(.WIDTH(16), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd1_data(b_rd1), .rd2_data(b_rd2),
        .sel_err(b_err), .wr_count(b_cnt)
    );

    rf_onehot_8x16 #(.WIDTH(16), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd1_data(n_rd1), .rd2_data(n_rd2),
        .sel_err(n_err), .wr_count(n_cnt)
    );

    typedef struct {
        int unsigned cyc;
        logic [15:0] b1, b2, n1, n2;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        q[$];
    string       nq[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    // Reference state, updated at each rising edge by the driver.
    logic [15:0] m_reg [8];
    logic        m_err;
    logic [7:0]  m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp16(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        exp_t  it;
        string nm;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            it = q.pop_front();
            nm = nq.pop_front();
            if (it.cyc != cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", nm, it.cyc, cyc);
            end else begin
                cmp16(nm, "byp_rd1", b_rd1, it.b1);
                cmp16(nm, "byp_rd2", b_rd2, it.b2);
                cmp16(nm, "nob_rd1", n_rd1, it.n1);
                cmp16(nm, "nob_rd2", n_rd2, it.n2);
                cmp16(nm, "byp_err", 16'(b_err), 16'(it.err));
                cmp16(nm, "nob_err", 16'(n_err), 16'(it.err));
                cmp16(nm, "byp_cnt", 16'(b_cnt), 16'(it.cnt));
                cmp16(nm, "nob_cnt", 16'(n_cnt), 16'(it.cnt));
            end
        end
    end

    // One cycle: drive inputs, queue the expectation for this cycle, advance the model at the edge.
    task automatic step(input string nm, input logic rst, input logic we, input logic [7:0] sel,
                        input logic [15:0] d, input logic [2:0] a1, input logic [2:0] a2, input bit chk);
        exp_t it;
        logic ok;
        rst_n = rst; wr_en = we; wr_sel = sel; wr_data = d; rd1_addr = a1; rd2_addr = a2;
        ok = we && ($countones(sel) == 1);
        if (chk) begin
            it.cyc = cyc;
            it.n1  = m_reg[a1];
            it.n2  = m_reg[a2];
            it.b1  = (ok && sel[a1]) ? d : m_reg[a1];
            it.b2  = (ok && sel[a2]) ? d : m_reg[a2];
            it.err = m_err;
            it.cnt = m_cnt;
            q.push_back(it);
            nq.push_back(nm);
        end
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
            m_err = 1'b0;
            m_cnt = 8'd0;
        end else if (we) begin
            if (ok) begin
                for (int i = 0; i < 8; i++) if (sel[i]) m_reg[i] = d;
                m_cnt = m_cnt + 8'd1;
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_err = 1'b0;
        m_cnt = 8'd0;

        // Reset held two cycles while a write is requested; that write must be discarded.
        step("rst0", 1'b0, 1'b1, 8'h01, 16'hFFFF, 3'd1, 3'd2, 1'b0);
        step("rst1", 1'b0, 1'b1, 8'h01, 16'hFFFF, 3'd1, 3'd2, 1'b1);
        step("post_rst", 1'b1, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd7, 1'b1);

        // Fill every register, then read all pairs back.
        for (int i = 0; i < 8; i++)
            step("fill", 1'b1, 1'b1, 8'(1 << i), 16'h1000 + 16'(i), 3'(i), 3'((i + 1) % 8), 1'b1);
        for (int i = 0; i < 8; i++)
            step("readback", 1'b1, 1'b0, 8'(i * 37), 16'hDEAD, 3'(i), 3'(7 - i), 1'b1);

        // Forwarding: both ports read R3 while it is being rewritten.
        step("r3_aaaa", 1'b1, 1'b1, 8'h08, 16'hAAAA, 3'd0, 3'd1, 1'b1);
        step("bypass",  1'b1, 1'b1, 8'h08, 16'h5555, 3'd3, 3'd3, 1'b1);
        step("after_byp", 1'b1, 1'b0, 8'h00, 16'h0000, 3'd3, 3'd3, 1'b1);

        // Back-to-back writes to one register; last value wins.
        step("b2b_1", 1'b1, 1'b1, 8'h04, 16'h1111, 3'd2, 3'd1, 1'b1);
        step("b2b_2", 1'b1, 1'b1, 8'h04, 16'h2222, 3'd2, 3'd1, 1'b1);
        step("b2b_rd", 1'b1, 1'b0, 8'h04, 16'h3333, 3'd2, 3'd1, 1'b1);

        // Idle write port ignores a malformed select.
        step("idle_ff", 1'b1, 1'b0, 8'hFF, 16'hBAD0, 3'd3, 3'd4, 1'b1);
        step("idle_chk", 1'b1, 1'b0, 8'h00, 16'h0000, 3'd3, 3'd4, 1'b1);

        // Malformed selects: no write, no count, sticky flag; never forwarded.
        step("bad_00", 1'b1, 1'b1, 8'h00, 16'hBAD1, 3'd0, 3'd1, 1'b1);
        step("bad_18", 1'b1, 1'b1, 8'h18, 16'hBAD2, 3'd3, 3'd4, 1'b1);
        step("bad_chk", 1'b1, 1'b0, 8'h00, 16'h0000, 3'd3, 3'd4, 1'b1);
        step("sticky", 1'b1, 1'b1, 8'h20, 16'h0505, 3'd6, 3'd7, 1'b1);

        // Reset coincident with a valid write to R5.
        step("rst_wr5", 1'b0, 1'b1, 8'h20, 16'hBEEF, 3'd4, 3'd6, 1'b1);
        step("rst_chk", 1'b1, 1'b0, 8'h00, 16'h0000, 3'd5, 3'd0, 1'b1);

        // Counter wrap: 256 writes return to 0, the 257th gives 1.
        for (int k = 0; k < 257; k++)
            step("wrap", 1'b1, 1'b1, 8'(1 << (k % 8)), 16'(k), 3'(k % 8), 3'((k + 3) % 8), 1'b1);
        step("wrap_end", 1'b1, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd7, 1'b1);

        for (int t = 0; t < 5 && q.size() > 0; t++) @(posedge clk);
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
